// File: rtl/dec_frac_pkg.sv
// rtl/dec_frac_pkg.sv - FSM state encoding, DEN constant and width helpers for dec_frac_to_bin
package dec_frac_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CONV  = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic int unsigned den_of(input int unsigned ddig);
    int unsigned d;
    d = 1;
    for (int unsigned i = 0; i < ddig; i++) d = d * 10;
    return d;
  endfunction

  function automatic int x_width(input int unsigned ddig);
    return $clog2(den_of(ddig));
  endfunction

  // Remainder holds 2*R before subtraction, so it needs one more value range than x_dec.
  function automatic int r_width(input int unsigned ddig);
    return $clog2(2 * den_of(ddig));
  endfunction

endpackage

// File: rtl/dec_frac_to_bin_if.sv
// rtl/dec_frac_to_bin_if.sv - request/result bundle between a requester and dec_frac_to_bin
interface dec_frac_to_bin_if #(
  parameter int NBITS = 8,
  parameter int DDIG  = 5
);
  import dec_frac_pkg::*;

  localparam int XW = x_width(DDIG);

  logic             start;
  logic [XW-1:0]    x_dec;
  logic             busy;
  logic             done;
  logic [0:NBITS-1] z_bi;
  logic             exact;
  logic             err;

  modport master (output start, x_dec, input busy, done, z_bi, exact, err);
  modport slave  (input start, x_dec, output busy, done, z_bi, exact, err);

endinterface

// File: rtl/frac_double_step.sv
// rtl/frac_double_step.sv - one combinational doubling step of decimal-fraction to binary conversion
module frac_double_step #(
  parameter int DDIG = 5,
  parameter int RW   = dec_frac_pkg::r_width(DDIG)
) (
  input  logic [RW-1:0] i_rem,
  output logic [RW-1:0] o_rem,
  output logic          o_bit
);
  import dec_frac_pkg::*;

  localparam logic [RW-1:0] DEN = RW'(den_of(DDIG));

  logic [RW-1:0] w_r2;

  assign w_r2  = i_rem << 1;
  assign o_bit = (w_r2 >= DEN);
  assign o_rem = o_bit ? (w_r2 - DEN) : w_r2;

endmodule

// File: rtl/dec_frac_to_bin.sv
// rtl/dec_frac_to_bin.sv - serial decimal fraction to binary converter; DEC_FRAC_TO_BIN_ROUND_EN enables round-to-nearest
module dec_frac_to_bin #(
  parameter int NBITS = 8,
  parameter int DDIG  = 5
) (
  input  logic              clk,
  input  logic              rst,
  dec_frac_to_bin_if.slave  bus
);
  import dec_frac_pkg::*;

  localparam int RW = r_width(DDIG);
  localparam int CW = $clog2(NBITS + 2);
`ifdef DEC_FRAC_TO_BIN_ROUND_EN
  localparam int STEPS = NBITS + 1;
`else
  localparam int STEPS = NBITS;
`endif
  localparam logic [CW-1:0]    LAST  = CW'(STEPS - 1);
  localparam logic [RW-1:0]    DEN   = RW'(den_of(DDIG));
  localparam logic [0:NBITS-1] Z_MSB = NBITS'(1) << (NBITS - 1);

  state_t           r_state;
  logic [RW-1:0]    r_rem;
  logic [CW-1:0]    r_cnt;
  logic [0:NBITS-1] r_z;
  logic             r_exact;
  logic             r_err;
`ifdef DEC_FRAC_TO_BIN_ROUND_EN
  logic             r_guard;
`endif

  logic [RW-1:0]    w_x;
  logic [RW-1:0]    w_rem_nxt;
  logic             w_bit;
  logic             w_last;
  logic [0:NBITS-1] w_mask;

  frac_double_step #(.DDIG(DDIG), .RW(RW)) u_step (
    .i_rem (r_rem),
    .o_rem (w_rem_nxt),
    .o_bit (w_bit)
  );

  assign w_x    = RW'(bus.x_dec);
  assign w_last = (r_cnt == LAST);
  // Mask walks off the end on the guard step, so the guard bit is never stored.
  assign w_mask = Z_MSB >> r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_exact <= 1'b0;
      r_err   <= 1'b0;
`ifdef DEC_FRAC_TO_BIN_ROUND_EN
      r_guard <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_rem   <= w_x;
            r_cnt   <= '0;
            r_z     <= '0;
            r_exact <= 1'b0;
            if (w_x >= DEN) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_bit) r_z <= r_z | w_mask;
          if (w_last) begin
`ifdef DEC_FRAC_TO_BIN_ROUND_EN
            r_guard <= w_bit;
            r_exact <= (w_rem_nxt == '0) && !w_bit;
            r_state <= ST_ROUND;
`else
            r_exact <= (w_rem_nxt == '0);
            r_state <= ST_DONE;
`endif
          end
        end
`ifdef DEC_FRAC_TO_BIN_ROUND_EN
        ST_ROUND: begin
          if (r_guard && !(&r_z)) r_z <= r_z + NBITS'(1);
          r_state <= ST_DONE;
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = (r_state == ST_CONV) || (r_state == ST_ROUND);
  assign bus.done  = (r_state == ST_DONE);
  assign bus.z_bi  = r_z;
  assign bus.exact = r_exact;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_dec_frac_to_bin.sv
// tb/tb_dec_frac_to_bin.sv - self-checking bench for dec_frac_to_bin against an arithmetic reference
module tb_dec_frac_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  int          sel;
  logic [16:0] x;
  int          checks = 0;
  int          errors = 0;

  logic        done_m, busy_m, exact_m, err_m;
  logic [7:0]  z_m;

  dec_frac_to_bin_if #(.NBITS(8), .DDIG(5)) bus0 ();
  dec_frac_to_bin_if #(.NBITS(5), .DDIG(5)) bus1 ();
  dec_frac_to_bin_if #(.NBITS(8), .DDIG(1)) bus2 ();
  dec_frac_to_bin_if #(.NBITS(4), .DDIG(5)) bus3 ();

  dec_frac_to_bin #(.NBITS(8), .DDIG(5)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dec_frac_to_bin #(.NBITS(5), .DDIG(5)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dec_frac_to_bin #(.NBITS(8), .DDIG(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  dec_frac_to_bin #(.NBITS(4), .DDIG(5)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  assign bus0.start = start && (sel == 0);
  assign bus1.start = start && (sel == 1);
  assign bus2.start = start && (sel == 2);
  assign bus3.start = start && (sel == 3);
  assign bus0.x_dec = x;
  assign bus1.x_dec = x;
  assign bus2.x_dec = x[3:0];
  assign bus3.x_dec = x;

  always_comb begin
    done_m = bus0.done; busy_m = bus0.busy; exact_m = bus0.exact; err_m = bus0.err; z_m = bus0.z_bi;
    case (sel)
      1: begin done_m = bus1.done; busy_m = bus1.busy; exact_m = bus1.exact; err_m = bus1.err; z_m = {3'b000, bus1.z_bi}; end
      2: begin done_m = bus2.done; busy_m = bus2.busy; exact_m = bus2.exact; err_m = bus2.err; z_m = bus2.z_bi; end
      3: begin done_m = bus3.done; busy_m = bus3.busy; exact_m = bus3.exact; err_m = bus3.err; z_m = {4'b0000, bus3.z_bi}; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // value = m / 10^dg; binary fraction bits = floor(value * 2^nb), optionally rounded on one more bit
  function automatic void model(input int nb, input int dg, input int m,
                                output longint z, output int ex, output int er, output int lat);
    longint den, q, rem;
    den = 1;
    for (int i = 0; i < dg; i++) den = den * 10;
    if (m >= den) begin
      z = 0; ex = 0; er = 1; lat = 1;
    end else begin
      er = 0;
`ifdef DEC_FRAC_TO_BIN_ROUND_EN
      q   = (longint'(m) << (nb + 1)) / den;
      rem = (longint'(m) << (nb + 1)) % den;
      z   = q / 2;
      ex  = (q % 2 == 0 && rem == 0) ? 1 : 0;
      if (q % 2 == 1) begin
        z = z + 1;
        if (z >= (longint'(1) << nb)) z = (longint'(1) << nb) - 1;
      end
      lat = nb + 3;
`else
      q   = (longint'(m) << nb) / den;
      rem = (longint'(m) << nb) % den;
      z   = q;
      ex  = (rem == 0) ? 1 : 0;
      lat = nb + 1;
`endif
    end
  endfunction

  task automatic run(input int s, input int m, input int nb, input int dg);
    longint ez;
    int eex, eer, elat, lat;
    model(nb, dg, m, ez, eex, eer, elat);
    @(negedge clk);
    sel = s; x = 17'(m); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    if (elat > 1) chk($sformatf("busy s%0d m%0d", s, m), busy_m, 1);
    while (!done_m && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency s%0d m%0d", s, m), lat, elat);
    chk($sformatf("z_bi s%0d m%0d", s, m), z_m, ez);
    chk($sformatf("exact s%0d m%0d", s, m), exact_m, eex);
    chk($sformatf("err s%0d m%0d", s, m), err_m, eer);
    @(negedge clk);
    chk($sformatf("done_pulse s%0d m%0d", s, m), done_m, 0);
    chk($sformatf("hold_z s%0d m%0d", s, m), z_m, ez);
  endtask

  initial begin
    longint ez;
    int eex, eer, elat, pulses;

    rst = 1'b1; start = 1'b0; sel = 0; x = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy_m, 0);
    chk("reset done", done_m, 0);
    chk("reset z_bi", z_m, 0);
    chk("reset exact", exact_m, 0);
    chk("reset err", err_m, 0);
    rst = 1'b0;

    run(1, 15625, 5, 5);
    run(2, 1, 8, 1);
    run(3, 99999, 4, 5);
    run(0, 100000, 8, 5);
    run(0, 0, 8, 5);
    run(0, 99999, 8, 5);
    run(0, 131071, 8, 5);
    run(0, 50000, 8, 5);
    run(2, 9, 8, 1);
    run(2, 10, 8, 1);
    run(2, 15, 8, 1);

    for (int i = 0; i < 24; i++) run(0, int'($urandom_range(0, 110000)), 8, 5);
    for (int i = 0; i < 6; i++)  run(2, int'($urandom_range(0, 15)), 8, 1);
    for (int i = 0; i < 6; i++)  run(1, int'($urandom_range(0, 99999)), 5, 5);

    // second start while converting must not disturb the first result
    model(8, 5, 37500, ez, eex, eer, elat);
    @(negedge clk);
    sel = 0; x = 17'd37500; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = 17'd99999;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_m) pulses++;
      @(negedge clk);
    end
    chk("midstart pulses", pulses, 1);
    chk("midstart z_bi", z_m, ez);
    chk("midstart exact", exact_m, eex);

    // reset during the third conversion cycle
    @(negedge clk);
    sel = 0; x = 17'd87654; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset busy", busy_m, 1);
    chk("pre-reset z_bi", z_m, 8'hC0);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", busy_m, 0);
    chk("abort done", done_m, 0);
    chk("abort z_bi", z_m, 0);
    chk("abort exact", exact_m, 0);
    chk("abort err", err_m, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done_m) pulses++;
      @(negedge clk);
    end
    chk("abort no done", pulses, 0);
    run(0, 50000, 8, 5);
    chk("after abort z_bi", z_m, 8'h80);
    chk("after abort exact", exact_m, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
